lcd_cmd_sched: RTL and testbench
================================

Name: lcd_cmd_sched

Overview:
- Scheduler in front of the LCD output core. It shares that core's 32-bit command-word input, format {valid, 11'b0, cmd[3:0], data[15:0]}, between two requesters.
- Requester 1: CPU single-word writes, buffered in a small FIFO.
- Requester 2: a hardware rectangle-fill engine. It emits the column/row window setup, then 0x2C00 (memory write), then N pixel data words.
- Words are paced at one per SLOT_CYCLES clocks, matching the core's write-strobe rate. Nothing is issued while the core reports init/boot-image activity.

Parameters:
- SLOT_CYCLES, 2, clocks each issued word is held on lcd_word (>=1).
- FIFO_DEPTH, 4, CPU word FIFO entries (power of 2).
- CMD_INST, 4'd1, cmd code for instruction words.
- CMD_DATA, 4'd2, cmd code for data words.

Ports:
- clk  in  1  system clock (33 MHz)
- rst  in  1  synchronous reset, active-high
- cpu_wvalid  in  1  CPU word write request
- cpu_wdata  in  32  {valid, 11'b0, cmd, data}
- cpu_wready  out  1  FIFO not full
- fill_start  in  1  one-cycle fill request
- fill_x0, fill_x1, fill_y0, fill_y1  in  10 each  inclusive window corners
- fill_color  in  16  RGB565 pixel value
- fill_busy  out  1  fill accepted and not yet finished
- fill_done  out  1  one-cycle pulse after the last pixel slot
- fill_err  out  1  one-cycle pulse when a request is rejected
- lcd_init_busy  in  1  output core busy with init/boot image
- lcd_word  out  32  command word to the output core
- cpu_fifo_cnt  out  3  CPU FIFO occupancy

Behaviour:
- Reset: every output is 0 except cpu_wready=1. FIFO empties, fill latches clear, last-grant pointer = CPU. Reset mid-transaction aborts it; lcd_word=0 on the next cycle.
- CPU push: a push occurs when cpu_wvalid & cpu_wready. A word with bit31=0 is accepted and discarded. Push and pop in the same cycle are allowed when full.
- Fill accept: fill_start & ~fill_busy & x1>=x0 & y1>=y0 latches coordinates and colour; fill_busy=1 from the next cycle.
- Fill reject, invalid window: fill_err pulses on the next cycle and nothing is latched.
- Fill reject, already busy: fill_start while fill_busy is ignored and fill_err pulses.
- FSM states: ARB, CPU_SLOT, FILL_HDR, FILL_PIX.
- ARB: lcd_word=0.
  - If lcd_init_busy, stay in ARB.
  - Otherwise grant between FIFO-nonempty and fill-pending by round-robin at transaction granularity. One CPU word is one transaction; a whole fill is one transaction. If only one side is pending, grant it.
  - The granted word appears on lcd_word the next cycle.
- CPU_SLOT: pop one word and hold it SLOT_CYCLES cycles, then return to ARB.
- FILL_HDR: 17 words, each held SLOT_CYCLES, no gaps between words:
  - INST 0x2A00, DATA {8'b0,6'b0,x0[9:8]}, INST 0x2A01, DATA x0[7:0], INST 0x2A02, DATA x1 hi, INST 0x2A03, DATA x1 lo.
  - The same 8-word pattern with 0x2B00..0x2B03 and y0/y1.
  - INST 0x2C00.
  - Then go to FILL_PIX.
- FILL_PIX: issue (x1-x0+1)*(y1-y0+1) DATA fill_color words. The count uses a 20-bit counter; max 1024*1024 wraps to 0, so use a count-minus-1 compare.
  - At the end of the last slot: fill_busy=0 and fill_done=1 for one cycle; return to ARB.
- Fill atomicity: a fill is never interrupted by CPU words. lcd_init_busy is sampled only in ARB.
- Latency: push/fill_start at T, lcd_word valid from T+2 at the earliest.
- Slot boundaries: lcd_word is always 0 for at least one ARB cycle between transactions. Inside a transaction lcd_word changes only on slot boundaries.
- Widths: words are composed as {1'b1, 11'b0, cmd, data}.

Decomposition:
- Shared package lcd_pkg holds:
  - CMD_INST and CMD_DATA.
  - Bit-field positions: VALID=31, CMD=19:16, DATA=15:0.
  - Opcodes 0x2A00, 0x2B00, 0x2C00, 0x2900.
  - FSM state encoding.
  - Header length 17.
- One sub-module, lcd_word_fifo: parameterised sync FIFO with count output, no read latency (show-ahead).

Test Plan:
- CPU burst: 5 pushes of {1,11'b0,1,16'h2900} with lcd_init_busy=0.
  - cpu_wready drops after 4 pushes.
  - Each word holds 2 cycles with a 0 cycle between words.
  - The 5th word is accepted after the first pop.
- Fill (0,0)-(1,1), colour 0xF800:
  - 17 header words match the exact sequence above, followed by 4 DATA 0xF800 words.
  - Words are contiguous.
  - fill_done pulses once; fill_busy is high from T+1 until the done cycle.
- Invalid fill x0=5, x1=4:
  - fill_err pulses at T+1.
  - fill_busy stays 0 and lcd_word stays 0.
- Contention: FIFO holds 2 words and a fill is pending, last grant = CPU.
  - Order is fill, CPU, CPU if no new fill.
  - A second fill_start during the first fill yields fill_err.
- lcd_init_busy=1 with pending work: lcd_word stays 0. Deassert busy at T: first word at T+1.
- Assert rst mid-FILL_PIX: lcd_word=0, fill_busy=0, cpu_fifo_cnt=0 next cycle, and no fill_done pulse.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared word format, opcodes, FSM encoding and header-word builder for the LCD scheduler
package lcd_pkg;
  localparam logic [3:0] CMD_INST = 4'd1;
  localparam logic [3:0] CMD_DATA = 4'd2;
  localparam int VALID_BIT = 31;
  localparam int CMD_MSB = 19;
  localparam int CMD_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;
  localparam logic [15:0] OP_CASET = 16'h2A00;
  localparam logic [15:0] OP_RASET = 16'h2B00;
  localparam logic [15:0] OP_RAMWR = 16'h2C00;
  localparam logic [15:0] OP_DISPON = 16'h2900;
  localparam logic [1:0] ST_ARB = 2'd0;
  localparam logic [1:0] ST_CPU_SLOT = 2'd1;
  localparam logic [1:0] ST_FILL_HDR = 2'd2;
  localparam logic [1:0] ST_FILL_PIX = 2'd3;
  localparam int HDR_LEN = 17;
  function automatic logic [31:0] mk_word(input logic [3:0] cmd, input logic [15:0] data);
    logic [31:0] w;
    w = '0;
    w[VALID_BIT] = 1'b1;
    w[CMD_MSB:CMD_LSB] = cmd;
    w[DATA_MSB:DATA_LSB] = data;
    return w;
  endfunction
  // i[3] picks column/row, i[2] start/end corner, i[1] low/high byte, i[0] data/instruction
  function automatic logic [31:0] hdr_word(input logic [4:0] i, input logic [9:0] x0, x1, y0, y1);
    logic [9:0] c;
    c = i[3] ? (i[2] ? y1 : y0) : (i[2] ? x1 : x0);
    if (i >= 5'(HDR_LEN - 1)) return mk_word(CMD_INST, OP_RAMWR);
    return i[0] ? mk_word(CMD_DATA, i[1] ? {8'b0, c[7:0]} : {14'b0, c[9:8]})
                : mk_word(CMD_INST, (i[3] ? OP_RASET : OP_CASET) | {14'b0, i[2:1]});
  endfunction
endpackage

// File: rtl/lcd_word_fifo.sv
// lcd_word_fifo: show-ahead synchronous FIFO with occupancy count
module lcd_word_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign rdata = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: round-robin scheduler of CPU words and rectangle fills onto the LCD command-word stream
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int SLOT_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_wvalid,
  input  logic [31:0]                   cpu_wdata,
  output logic                          cpu_wready,
  input  logic                          fill_start,
  input  logic [9:0]                    fill_x0,
  input  logic [9:0]                    fill_x1,
  input  logic [9:0]                    fill_y0,
  input  logic [9:0]                    fill_y1,
  input  logic [15:0]                   fill_color,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          fill_err,
  input  logic                          lcd_init_busy,
  output logic [31:0]                   lcd_word,
  output logic [$clog2(FIFO_DEPTH):0]   cpu_fifo_cnt
);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  logic [1:0] state;
  logic [SW-1:0] sc;
  logic [4:0] idx;
  logic [19:0] pix, pix_last;
  logic [10:0] w, h;
  logic [9:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0] color_q;
  logic [31:0] fifo_rdata;
  logic fifo_full, fifo_empty, last_fill, win_ok, slot_end, grant_cpu, grant_fill;
  assign cpu_wready = ~fifo_full;
  assign win_ok = fill_x1 >= fill_x0 && fill_y1 >= fill_y0;
  assign slot_end = sc == SW'(SLOT_CYCLES - 1);
  assign w = {1'b0, x1_q} - {1'b0, x0_q} + 11'd1;
  assign h = {1'b0, y1_q} - {1'b0, y0_q} + 11'd1;
  // a full 1024x1024 window wraps the product to 0, so the last index is all ones
  assign pix_last = 20'(20'(w) * 20'(h)) - 20'd1;
  assign grant_fill = state == ST_ARB && !lcd_init_busy && fill_busy && (fifo_empty || !last_fill);
  assign grant_cpu = state == ST_ARB && !lcd_init_busy && !fifo_empty && !grant_fill;
  lcd_word_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cpu_wvalid & cpu_wready & cpu_wdata[VALID_BIT]),
    .wdata(cpu_wdata),
    .pop(grant_cpu),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .cnt(cpu_fifo_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ARB;
      sc <= '0;
      idx <= '0;
      pix <= '0;
      last_fill <= 1'b0;
      lcd_word <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      fill_err <= 1'b0;
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
      color_q <= '0;
    end else begin
      fill_err <= fill_start & (fill_busy | ~win_ok);
      fill_done <= 1'b0;
      sc <= (state != ST_ARB && !slot_end) ? sc + SW'(1) : '0;
      if (fill_start & ~fill_busy & win_ok) begin
        x0_q <= fill_x0;
        x1_q <= fill_x1;
        y0_q <= fill_y0;
        y1_q <= fill_y1;
        color_q <= fill_color;
        fill_busy <= 1'b1;
      end
      case (state)
        ST_ARB: begin
          if (grant_cpu) begin
            state <= ST_CPU_SLOT;
            lcd_word <= fifo_rdata;
            last_fill <= 1'b0;
          end else if (grant_fill) begin
            state <= ST_FILL_HDR;
            idx <= '0;
            lcd_word <= hdr_word(5'd0, x0_q, x1_q, y0_q, y1_q);
            last_fill <= 1'b1;
          end
        end
        ST_CPU_SLOT: begin
          if (slot_end) begin
            state <= ST_ARB;
            lcd_word <= '0;
          end
        end
        ST_FILL_HDR: begin
          if (slot_end && idx == 5'(HDR_LEN - 1)) begin
            state <= ST_FILL_PIX;
            pix <= '0;
            lcd_word <= mk_word(CMD_DATA, color_q);
          end else if (slot_end) begin
            idx <= idx + 5'd1;
            lcd_word <= hdr_word(idx + 5'd1, x0_q, x1_q, y0_q, y1_q);
          end
        end
        ST_FILL_PIX: begin
          if (slot_end && pix == pix_last) begin
            state <= ST_ARB;
            lcd_word <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else if (slot_end) begin
            pix <= pix + 20'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb_lcd_cmd_sched: table-driven CPU/invalid-fill vectors plus directed fill, contention and reset sequences
module tb_lcd_cmd_sched;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0;
  logic rst, cpu_wvalid, cpu_wready, fill_start, fill_busy, fill_done, fill_err, lcd_init_busy;
  logic [31:0] cpu_wdata, lcd_word;
  logic [9:0] fill_x0, fill_x1, fill_y0, fill_y1;
  logic [15:0] fill_color;
  logic [2:0] cpu_fifo_cnt;
  int n_pass = 0;
  int n_tot = 0;
  logic [31:0] cw [5];
  logic [31:0] expq [$];
  typedef struct {
    logic wv;
    logic [31:0] wd;
    logic fs;
    logic ib;
    logic [31:0] lw;
    logic rdy;
    logic [2:0] cnt;
    logic err;
  } vec_t;
  vec_t tbl [23];
  always #5 clk = ~clk;
  lcd_cmd_sched dut (
    .clk(clk), .rst(rst), .cpu_wvalid(cpu_wvalid), .cpu_wdata(cpu_wdata), .cpu_wready(cpu_wready),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1), .fill_y0(fill_y0), .fill_y1(fill_y1),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
    .lcd_init_busy(lcd_init_busy), .lcd_word(lcd_word), .cpu_fifo_cnt(cpu_fifo_cnt)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  function automatic logic [31:0] inst(input logic [15:0] d);
    return {16'h8001, d};
  endfunction
  function automatic logic [31:0] dat(input logic [15:0] d);
    return {16'h8002, d};
  endfunction
  function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic fs, input logic ib,
                              input logic [31:0] lw, input logic rdy, input logic [2:0] cnt, input logic err);
    vec_t v;
    v.wv = wv;
    v.wd = wd;
    v.fs = fs;
    v.ib = ib;
    v.lw = lw;
    v.rdy = rdy;
    v.cnt = cnt;
    v.err = err;
    return v;
  endfunction
  task automatic build_exp(input logic [9:0] a0, a1, b0, b1, input logic [15:0] col, input int npix);
    logic [9:0] cs [4];
    logic [9:0] c;
    cs[0] = a0;
    cs[1] = a1;
    cs[2] = b0;
    cs[3] = b1;
    expq.delete();
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 4; k++) begin
        c = cs[2*g + k/2];
        expq.push_back(inst((g == 1 ? 16'h2B00 : 16'h2A00) + 16'(k)));
        expq.push_back(dat((k % 2 == 1) ? {8'h00, c[7:0]} : {14'h0, c[9:8]}));
      end
    expq.push_back(inst(16'h2C00));
    for (int p = 0; p < npix; p++) expq.push_back(dat(col));
  endtask
  // each expected word is held two cycles; ends on the done cycle
  task automatic run_fill(input int start);
    for (int j = start; j < 2 * expq.size(); j++) begin
      step();
      chk($sformatf("fill word %0d", j / 2), lcd_word, expq[j/2]);
      chk($sformatf("fill busy c%0d", j), {31'b0, fill_busy}, 32'd1);
      chk($sformatf("fill done early c%0d", j), {31'b0, fill_done}, 32'd0);
    end
    step();
    chk("fill end lcd_word", lcd_word, 32'd0);
    chk("fill end busy", {31'b0, fill_busy}, 32'd0);
    chk("fill end done", {31'b0, fill_done}, 32'd1);
  endtask
  initial begin
    logic bad;
    rst = 1'b1;
    cpu_wvalid = 1'b0;
    cpu_wdata = '0;
    fill_start = 1'b0;
    lcd_init_busy = 1'b0;
    fill_x0 = 10'd5;
    fill_x1 = 10'd4;
    fill_y0 = 10'd0;
    fill_y1 = 10'd0;
    fill_color = 16'h0;
    for (int i = 0; i < 5; i++) cw[i] = 32'h8001_2900 + 32'(i);
    tbl[0]  = mk(H, cw[0], L, H, 32'd0, H, 3'd1, L);
    tbl[1]  = mk(H, cw[1], L, H, 32'd0, H, 3'd2, L);
    tbl[2]  = mk(H, cw[2], L, H, 32'd0, H, 3'd3, L);
    tbl[3]  = mk(H, cw[3], L, H, 32'd0, L, 3'd4, L);
    tbl[4]  = mk(H, cw[4], L, L, cw[0], H, 3'd3, L);
    tbl[5]  = mk(H, cw[4], L, L, cw[0], L, 3'd4, L);
    tbl[6]  = mk(L, 32'd0, L, L, 32'd0, L, 3'd4, L);
    tbl[7]  = mk(L, 32'd0, L, L, cw[1], H, 3'd3, L);
    tbl[8]  = mk(H, 32'h0001_1234, L, L, cw[1], H, 3'd3, L);
    tbl[9]  = mk(L, 32'd0, L, L, 32'd0, H, 3'd3, L);
    tbl[10] = mk(L, 32'd0, L, L, cw[2], H, 3'd2, L);
    tbl[11] = mk(L, 32'd0, L, L, cw[2], H, 3'd2, L);
    tbl[12] = mk(L, 32'd0, L, L, 32'd0, H, 3'd2, L);
    tbl[13] = mk(L, 32'd0, L, L, cw[3], H, 3'd1, L);
    tbl[14] = mk(L, 32'd0, L, L, cw[3], H, 3'd1, L);
    tbl[15] = mk(L, 32'd0, L, L, 32'd0, H, 3'd1, L);
    tbl[16] = mk(L, 32'd0, L, L, cw[4], H, 3'd0, L);
    tbl[17] = mk(L, 32'd0, L, L, cw[4], H, 3'd0, L);
    tbl[18] = mk(L, 32'd0, L, L, 32'd0, H, 3'd0, L);
    tbl[19] = mk(L, 32'd0, L, L, 32'd0, H, 3'd0, L);
    tbl[20] = mk(L, 32'd0, H, L, 32'd0, H, 3'd0, H);
    tbl[21] = mk(L, 32'd0, L, L, 32'd0, H, 3'd0, L);
    tbl[22] = mk(L, 32'd0, L, L, 32'd0, H, 3'd0, L);
    step();
    step();
    rst = 1'b0;
    chk("reset lcd_word", lcd_word, 32'd0);
    chk("reset wready", {31'b0, cpu_wready}, 32'd1);
    chk("reset cnt", {29'b0, cpu_fifo_cnt}, 32'd0);
    chk("reset busy", {31'b0, fill_busy}, 32'd0);
    chk("reset done", {31'b0, fill_done}, 32'd0);
    chk("reset err", {31'b0, fill_err}, 32'd0);
    for (int i = 0; i < 23; i++) begin
      cpu_wvalid = tbl[i].wv;
      cpu_wdata = tbl[i].wd;
      fill_start = tbl[i].fs;
      lcd_init_busy = tbl[i].ib;
      step();
      chk($sformatf("r%0d lcd_word", i), lcd_word, tbl[i].lw);
      chk($sformatf("r%0d wready", i), {31'b0, cpu_wready}, {31'b0, tbl[i].rdy});
      chk($sformatf("r%0d cnt", i), {29'b0, cpu_fifo_cnt}, {29'b0, tbl[i].cnt});
      chk($sformatf("r%0d err", i), {31'b0, fill_err}, {31'b0, tbl[i].err});
      chk($sformatf("r%0d busy", i), {31'b0, fill_busy}, 32'd0);
    end
    cpu_wvalid = 1'b0;
    fill_start = 1'b0;
    lcd_init_busy = 1'b0;
    fill_x0 = 10'd0;
    fill_x1 = 10'd1;
    fill_y0 = 10'd0;
    fill_y1 = 10'd1;
    fill_color = 16'hF800;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    chk("fill1 accept busy", {31'b0, fill_busy}, 32'd1);
    chk("fill1 accept lcd_word", lcd_word, 32'd0);
    chk("fill1 accept err", {31'b0, fill_err}, 32'd0);
    build_exp(10'd0, 10'd1, 10'd0, 10'd1, 16'hF800, 4);
    run_fill(0);
    step();
    chk("fill1 done pulse", {31'b0, fill_done}, 32'd0);
    cpu_wvalid = 1'b1;
    cpu_wdata = 32'h8001_2900;
    step();
    cpu_wvalid = 1'b0;
    step();
    chk("c0 word", lcd_word, 32'h8001_2900);
    lcd_init_busy = 1'b1;
    cpu_wvalid = 1'b1;
    cpu_wdata = 32'h8002_00A1;
    fill_x0 = 10'h1FE;
    fill_x1 = 10'h200;
    fill_y0 = 10'h301;
    fill_y1 = 10'h301;
    fill_color = 16'h07E0;
    fill_start = 1'b1;
    step();
    chk("fill2 accept busy", {31'b0, fill_busy}, 32'd1);
    chk("c1 pushed cnt", {29'b0, cpu_fifo_cnt}, 32'd1);
    cpu_wdata = 32'h8002_00A2;
    fill_start = 1'b0;
    step();
    chk("c2 pushed cnt", {29'b0, cpu_fifo_cnt}, 32'd2);
    cpu_wvalid = 1'b0;
    step();
    chk("init busy holds lcd_word", lcd_word, 32'd0);
    chk("init busy holds cnt", {29'b0, cpu_fifo_cnt}, 32'd2);
    build_exp(10'h1FE, 10'h200, 10'h301, 10'h301, 16'h07E0, 3);
    fill_x0 = 10'd0;
    fill_x1 = 10'd0;
    fill_y0 = 10'd0;
    fill_y1 = 10'd0;
    fill_color = 16'h0000;
    fill_start = 1'b1;
    lcd_init_busy = 1'b0;
    step();
    fill_start = 1'b0;
    chk("fill2 first word", lcd_word, expq[0]);
    chk("busy fill_start err", {31'b0, fill_err}, 32'd1);
    run_fill(1);
    step();
    chk("after fill c1", lcd_word, 32'h8002_00A1);
    chk("after fill cnt", {29'b0, cpu_fifo_cnt}, 32'd1);
    step();
    chk("c1 hold", lcd_word, 32'h8002_00A1);
    step();
    chk("c1-c2 gap", lcd_word, 32'd0);
    step();
    chk("c2 word", lcd_word, 32'h8002_00A2);
    step();
    chk("c2 hold", lcd_word, 32'h8002_00A2);
    step();
    chk("c2 gap", lcd_word, 32'd0);
    fill_x0 = 10'd0;
    fill_x1 = 10'd1;
    fill_y0 = 10'd0;
    fill_y1 = 10'd1;
    fill_color = 16'hF800;
    fill_start = 1'b1;
    cpu_wvalid = 1'b1;
    cpu_wdata = cw[0];
    step();
    fill_start = 1'b0;
    cpu_wvalid = 1'b0;
    chk("fill3 busy", {31'b0, fill_busy}, 32'd1);
    chk("fill3 cnt", {29'b0, cpu_fifo_cnt}, 32'd1);
    repeat (35) step();
    chk("fill3 in pix", lcd_word, 32'h8002_F800);
    chk("fill3 cpu waiting", {29'b0, cpu_fifo_cnt}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst lcd_word", lcd_word, 32'd0);
    chk("mid rst busy", {31'b0, fill_busy}, 32'd0);
    chk("mid rst cnt", {29'b0, cpu_fifo_cnt}, 32'd0);
    chk("mid rst done", {31'b0, fill_done}, 32'd0);
    chk("mid rst wready", {31'b0, cpu_wready}, 32'd1);
    bad = 1'b0;
    repeat (12) begin
      step();
      if (fill_done || fill_busy || lcd_word != 32'd0) bad = 1'b1;
    end
    chk("post rst quiet", {31'b0, bad}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
